instr_fetch_unit: RTL and testbench

Fetch stage between the single-cycle datapath's `PC` output and a variable-latency instruction memory. It returns `Instr` from a one-entry fetch buffer when the buffered tag matches `PC`. On a miss it raises `Stall`, which the top level uses to freeze the PC register and suppress RegWrite/MemWrite. It then runs a req/ack transaction and refills the buffer; a watchdog substitutes a NOP and flags an error if memory never answers.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_timer.sv | 42 ++++
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage.
//   fetch_state_t   : fetch controller states (IDLE, REQ, ERR)
//   NOP_INSTR       : instruction word handed to the datapath while stalled
//                     and substituted for a fetch that timed out
//   DEFAULT_TIMEOUT : default number of unanswered request cycles tolerated
// ---------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ERR  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
   localparam int          DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/fetch_timer.sv
// ---------------------------------------------------------------------------
// fetch_timer
// Clearable saturating up-counter that watches an outstanding memory request.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   clear : synchronous clear, takes priority over inc
//   inc   : count one more unanswered request cycle
//   done  : high while the count equals TIMEOUT
// ---------------------------------------------------------------------------
module fetch_timer
   import fetch_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic done
);

   localparam int                  CountWidth = $clog2(TIMEOUT + 1);
   localparam logic [CountWidth-1:0] Limit    = CountWidth'(TIMEOUT);

   logic [CountWidth-1:0] count;

   // Saturates at the limit so a stuck inc can never wrap back to zero and
   // hide a timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && !done) begin
         count <= count + CountWidth'(1);
      end
   end

   assign done = (count == Limit);

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage with a one-entry fetch buffer in front of a variable-latency
// instruction memory. A buffer hit returns the instruction combinationally;
// a miss stalls the datapath while a req/ack transaction refills the buffer.
// A request left unanswered too long is replaced by a NOP and flagged.
// Ports:
//   CLK      : clock, rising edge
//   Reset    : asynchronous active-high reset
//   PC       : word fetch address from the datapath
//   Instr    : instruction to the datapath (NOP while stalled)
//   Stall    : high when Instr is not valid for the current PC
//   MemReq   : registered request strobe to instruction memory
//   MemAddr  : registered request address, stable while MemReq is high
//   MemAck   : one-cycle response strobe from memory
//   MemRData : response data, valid with MemAck
//   FetchErr : sticky timeout flag, cleared only by Reset
// ---------------------------------------------------------------------------
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic [ADDR_WIDTH-1:0] PC,
   output logic [DATA_WIDTH-1:0] Instr,
   output logic                  Stall,
   output logic                  MemReq,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   input  logic                  MemAck,
   input  logic [DATA_WIDTH-1:0] MemRData,
   output logic                  FetchErr
);

   localparam logic [DATA_WIDTH-1:0] Nop = DATA_WIDTH'(NOP_INSTR);

   fetch_state_t state;
   fetch_state_t state_next;

   logic                  buf_valid;
   logic [ADDR_WIDTH-1:0] buf_tag;
   logic [DATA_WIDTH-1:0] buf_data;

   logic hit;
   logic timer_clear;
   logic timer_inc;
   logic timer_done;

   fetch_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk   (CLK),
      .rst   (Reset),
      .clear (timer_clear),
      .inc   (timer_inc),
      .done  (timer_done)
   );

   // A hit is only honoured in IDLE so the buffer is never read on the same
   // cycle it is being refilled or overwritten with an error NOP.
   assign hit   = (state == IDLE) && buf_valid && (buf_tag == PC);
   assign Stall = !hit;
   assign Instr = hit ? buf_data : Nop;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The timeout is taken only when the count has already reached TIMEOUT
   // and this cycle still has no ack, so an ack on that last cycle wins and
   // the request stays up for TIMEOUT+1 cycles before it is abandoned.
   always_comb begin
      state_next  = state;
      timer_clear = 1'b0;
      timer_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (!hit) begin
               state_next  = REQ;
               timer_clear = 1'b1;
            end
         end
         REQ: begin
            if (MemAck) begin
               state_next = IDLE;
            end else if (timer_done) begin
               state_next = ERR;
            end else begin
               timer_inc = 1'b1;
            end
         end
         ERR: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // MemReq is registered from the next state so it rises with the first
   // REQ cycle and drops together with the ack or timeout. The fill tag comes
   // from the latched MemAddr, not PC, because PC may have moved on while the
   // request was outstanding.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         MemReq    <= 1'b0;
         MemAddr   <= '0;
         FetchErr  <= 1'b0;
         buf_valid <= 1'b0;
         buf_tag   <= '0;
         buf_data  <= '0;
      end else begin
         MemReq <= (state_next == REQ);
         case (state)
            IDLE: begin
               if (!hit) begin
                  MemAddr <= PC;
               end
            end
            REQ: begin
               if (MemAck) begin
                  buf_data  <= MemRData;
                  buf_tag   <= MemAddr;
                  buf_valid <= 1'b1;
               end
            end
            ERR: begin
               buf_data  <= Nop;
               buf_tag   <= MemAddr;
               buf_valid <= 1'b1;
               FetchErr  <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit. A small memory responder drives
// MemAck/MemRData, a transaction-level model predicts every output each
// cycle, and directed scenarios pin stall/request lengths with literals.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam int TO    = 15;
   localparam int NEVER = 1000;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [31:0] PC;
   logic [31:0] Instr;
   logic        Stall;
   logic        MemReq;
   logic [31:0] MemAddr;
   logic        MemAck;
   logic [31:0] MemRData;
   logic        FetchErr;

   int checks = 0;
   int errors = 0;

   int ack_delay     = 0;
   int req_cycles    = 0;
   bit stray_en      = 1'b0;
   bit random_delays = 1'b0;

   bit count_en  = 1'b0;
   int stall_cnt = 0;
   int req_cnt   = 0;

   // Model: the buffer contents, at most one outstanding request with its
   // age in request cycles, a pending error substitution and the sticky flag.
   bit          m_valid   = 1'b0;
   logic [31:0] m_tag     = '0;
   logic [31:0] m_data    = '0;
   logic [31:0] m_addr    = '0;
   bit          m_pending = 1'b0;
   int          m_age     = 0;
   bit          m_err_now = 1'b0;
   bit          m_err     = 1'b0;
   bit          cmp_hit;

   instr_fetch_unit #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .TIMEOUT    (TO)
   ) dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .PC       (PC),
      .Instr    (Instr),
      .Stall    (Stall),
      .MemReq   (MemReq),
      .MemAddr  (MemAddr),
      .MemAck   (MemAck),
      .MemRData (MemRData),
      .FetchErr (FetchErr)
   );

   always #5 CLK = ~CLK;

   // Contents of the simulated instruction memory.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      if (addr == 32'd0) begin
         return 32'h2008_0005;
      end
      return (addr * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of memory response, then advances to just after the
   // next rising edge. The ack comes ack_delay cycles after the request
   // first appears; stray acks are thrown in only while nothing is requested.
   task automatic apply_stimulus();
      if (MemReq === 1'b1) begin
         if (req_cycles == 0 && random_delays) begin
            ack_delay = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 5));
         end
         req_cycles++;
         if (req_cycles == ack_delay + 1) begin
            MemAck   = 1'b1;
            MemRData = mem_word(MemAddr);
         end else begin
            MemAck   = 1'b0;
            MemRData = $urandom;
         end
      end else begin
         req_cycles = 0;
         MemAck     = stray_en && ($urandom_range(0, 3) == 0);
         MemRData   = $urandom;
      end
      @(posedge CLK);
      #1;
   endtask

   // Model update: a fill or error lands on the buffer at the end of the
   // cycle it happens; a miss with nothing outstanding issues a request.
   always @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         m_valid   <= 1'b0;
         m_tag     <= '0;
         m_data    <= '0;
         m_addr    <= '0;
         m_pending <= 1'b0;
         m_age     <= 0;
         m_err_now <= 1'b0;
         m_err     <= 1'b0;
      end else if (m_err_now) begin
         m_valid   <= 1'b1;
         m_tag     <= m_addr;
         m_data    <= 32'd0;
         m_err     <= 1'b1;
         m_err_now <= 1'b0;
      end else if (m_pending) begin
         if (MemAck) begin
            m_valid   <= 1'b1;
            m_tag     <= m_addr;
            m_data    <= MemRData;
            m_pending <= 1'b0;
         end else if (m_age == TO + 1) begin
            m_pending <= 1'b0;
            m_err_now <= 1'b1;
         end else begin
            m_age <= m_age + 1;
         end
      end else if (!(m_valid && m_tag == PC)) begin
         m_pending <= 1'b1;
         m_addr    <= PC;
         m_age     <= 1;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge CLK) begin
      cmp_hit = !m_pending && !m_err_now && m_valid && (m_tag == PC);
      check_output("stall", {31'd0, Stall}, {31'd0, !cmp_hit});
      check_output("instr", Instr, cmp_hit ? m_data : 32'd0);
      check_output("memreq", {31'd0, MemReq}, {31'd0, m_pending});
      check_output("memaddr", MemAddr, m_addr);
      check_output("fetcherr", {31'd0, FetchErr}, {31'd0, m_err});
   end

   always @(negedge CLK) begin
      if (count_en) begin
         if (Stall) stall_cnt++;
         if (MemReq) req_cnt++;
      end
   end

   task automatic start_window();
      stall_cnt = 0;
      req_cnt   = 0;
      count_en  = 1'b1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      Reset    = 1'b1;
      PC       = 32'd0;
      MemAck   = 1'b0;
      MemRData = 32'd0;

      @(posedge CLK);
      #1;
      $display("[TB] reset values");
      check_output("rst_memreq", {31'd0, MemReq}, 32'd0);
      check_output("rst_stall", {31'd0, Stall}, 32'd1);
      check_output("rst_instr", Instr, 32'd0);
      check_output("rst_memaddr", MemAddr, 32'd0);
      check_output("rst_fetcherr", {31'd0, FetchErr}, 32'd0);

      $display("[TB] zero-wait fill at PC 0, then hold");
      Reset     = 1'b0;
      ack_delay = 0;
      start_window();
      repeat (12) apply_stimulus();
      check_output("t1_stall_cycles", stall_cnt, 32'd2);
      check_output("t1_req_cycles", req_cnt, 32'd1);
      check_output("t1_instr", Instr, 32'h2008_0005);
      check_output("t1_stall", {31'd0, Stall}, 32'd0);
      check_output("t1_memaddr", MemAddr, 32'd0);

      $display("[TB] three-cycle ack delay at PC 7");
      PC        = 32'd7;
      ack_delay = 3;
      start_window();
      repeat (10) apply_stimulus();
      check_output("t2_stall_cycles", stall_cnt, 32'd5);
      check_output("t2_req_cycles", req_cnt, 32'd4);
      check_output("t2_memaddr", MemAddr, 32'd7);
      check_output("t2_instr", Instr, mem_word(32'd7));

      $display("[TB] PC moves 7 to 9 during a request");
      PC        = 32'd3;
      ack_delay = 0;
      repeat (4) apply_stimulus();
      PC        = 32'd7;
      ack_delay = 3;
      start_window();
      repeat (2) apply_stimulus();
      PC = 32'd9;
      repeat (10) apply_stimulus();
      check_output("t3_stall_cycles", stall_cnt, 32'd10);
      check_output("t3_req_cycles", req_cnt, 32'd8);
      check_output("t3_memaddr", MemAddr, 32'd9);
      check_output("t3_instr", Instr, mem_word(32'd9));

      $display("[TB] memory never answers");
      PC        = 32'd40;
      ack_delay = NEVER;
      start_window();
      repeat (23) apply_stimulus();
      check_output("t4_stall_cycles", stall_cnt, 32'd18);
      check_output("t4_req_cycles", req_cnt, 32'd16);
      check_output("t4_fetcherr", {31'd0, FetchErr}, 32'd1);
      check_output("t4_instr", Instr, 32'd0);
      check_output("t4_stall", {31'd0, Stall}, 32'd0);

      PC        = 32'd41;
      ack_delay = 1;
      start_window();
      repeat (6) apply_stimulus();
      check_output("t4b_stall_cycles", stall_cnt, 32'd3);
      check_output("t4b_req_cycles", req_cnt, 32'd2);
      check_output("t4b_instr", Instr, mem_word(32'd41));
      check_output("t4b_fetcherr", {31'd0, FetchErr}, 32'd1);
      count_en = 1'b0;

      $display("[TB] reset in the middle of a request, stray ack after");
      PC        = 32'd50;
      ack_delay = NEVER;
      repeat (3) apply_stimulus();
      check_output("t5_req_before", {31'd0, MemReq}, 32'd1);
      Reset = 1'b1;
      #1;
      check_output("t5_async_memreq", {31'd0, MemReq}, 32'd0);
      check_output("t5_async_stall", {31'd0, Stall}, 32'd1);
      check_output("t5_async_fetcherr", {31'd0, FetchErr}, 32'd0);
      @(posedge CLK);
      #1;
      Reset = 1'b0;
      start_window();
      MemAck   = 1'b1;
      MemRData = 32'hDEAD_BEEF;
      @(posedge CLK);
      #1;
      MemAck     = 1'b0;
      req_cycles = 0;
      ack_delay  = 2;
      repeat (5) apply_stimulus();
      check_output("t5_stall_cycles", stall_cnt, 32'd4);
      check_output("t5_req_cycles", req_cnt, 32'd3);
      check_output("t5_instr", Instr, mem_word(32'd50));
      check_output("t5_memaddr", MemAddr, 32'd50);
      count_en = 1'b0;

      $display("[TB] randomized traffic");
      stray_en      = 1'b1;
      random_delays = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            PC = $urandom_range(0, 15);
         end
         if ($urandom_range(0, 399) == 0) begin
            Reset = 1'b1;
            #2;
            Reset = 1'b0;
         end
         apply_stimulus();
      end
      stray_en      = 1'b0;
      random_delays = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
